regfile_wb_arbiter: RTL and testbench

Write-back arbiter and pending-write scoreboard for the 32×32 register file. Shares the register file's single write port (write data, write address, write enable) among NUM_REQ write-back requesters using round-robin arbitration behind a valid/ready handshake. Tracks destination registers with an outstanding write so issue logic can stall on read-after-write hazards. Sits between the execution/load units and the register file.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and the one-hot grant type
// Purpose: widths common to the register file, its write-back arbiter and the
//          hazard scoreboard.
// Contents: XLEN, REG_ADDR_W, NUM_REGS, MAX_REQ, grant_t.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  // Widest requester count the arbiter supports; narrower configurations
  // leave the upper grant bits at zero.
  localparam int MAX_REQ    = 4;

  typedef logic [MAX_REQ-1:0] grant_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back requester, register-file write and scoreboard bus
// Purpose: bundles the signals between the execution/load units, the issue
//          logic and the write-back arbiter.
// Signals: req_valid/req_ready/req_addr/req_data (requester handshake, slice i
//          belongs to requester i), wr_en/wr_addr/wr_data (register-file write
//          port), issue_valid/issue_rd (issuing destination), busy (pending writes).
// Modports: master = requesters/issue side, slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import regfile_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*XLEN-1:0]       req_data;
  logic                          wr_en;
  logic [REG_ADDR_W-1:0]         wr_addr;
  logic [XLEN-1:0]               wr_data;
  logic                          issue_valid;
  logic [REG_ADDR_W-1:0]         issue_rd;
  logic [NUM_REGS-1:0]           busy;

  modport master (
    output req_valid, req_addr, req_data, issue_valid, issue_rd,
    input  req_ready, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, issue_valid, issue_rd,
    output req_ready, wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first requester at or after the pointer (wrapping).
// Ports: i_req (request vector), i_ptr (search start), o_grant (one-hot grant),
//        o_winner (granted index), o_valid (any grant), o_ptr_next (pointer
//        after a grant: winner + 1 modulo NUM_REQ).
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output grant_t             o_grant,
  output logic [PTR_W-1:0]   o_winner,
  output logic               o_valid,
  output logic [PTR_W-1:0]   o_ptr_next
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    // Walk offsets from farthest to nearest so the closest valid index
    // to the pointer is the last one written and therefore wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(off);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (i_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
    o_grant    = o_valid ? (grant_t'(1) << o_winner) : '0;
    o_ptr_next = (o_winner == PTR_W'(NUM_REQ - 1)) ? '0 : o_winner + 1'b1;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter with pending-write scoreboard
// Purpose: shares the register file's single write port among NUM_REQ
//          requesters and tracks destinations with an outstanding write.
// Ports: clock (rising edge), reset (asynchronous, active-low),
//        bus (regfile_wb_arbiter_if.slave: requester handshake, register-file
//        write port, issue destination, busy vector).
// Config: RF_SCOREBOARD_EN enables busy tracking; without it busy is tied to 0.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      r_ptr;
  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [XLEN-1:0]       r_wr_data;

  grant_t                w_grant;
  logic [PTR_W-1:0]      w_winner;
  logic [PTR_W-1:0]      w_ptr_next;
  logic                  w_any;
  logic [REG_ADDR_W-1:0] w_sel_addr;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_unused_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req      (bus.req_valid),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_winner   (w_winner),
    .o_valid    (w_any),
    .o_ptr_next (w_ptr_next)
  );

  // The register file always accepts, so ready is the grant itself;
  // it is masked while reset is held so nothing is consumed then.
  assign bus.req_ready  = reset ? w_grant[NUM_REQ-1:0] : '0;
  assign w_unused_grant = ^(w_grant >> NUM_REQ);

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == PTR_W'(i)) begin
        w_sel_addr = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        w_sel_data = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_any) begin
      r_ptr     <= w_ptr_next;
      r_wr_addr <= w_sel_addr;
      r_wr_data <= w_sel_data;
      // x0 results are consumed but never reach the register file.
      r_wr_en   <= (w_sel_addr != '0);
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

`ifdef RF_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;

  // Clear on the edge the register file commits; the set is applied after
  // the clear so an issue to the same register in that cycle wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_wr_en) begin
      w_busy_next[r_wr_addr] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != '0)) begin
      w_busy_next[bus.issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign bus.busy = r_busy;
`else
  logic w_unused_issue;

  assign bus.busy       = '0;
  assign w_unused_issue = bus.issue_valid ^ (^bus.issue_rd);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard testbench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NR = 2;
`ifdef RF_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  regfile_wb_arbiter_if #(.NUM_REQ(NR)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_grant_q[$];
  wr_t  exp_wr_q[$];
  int   mon_g;
  wr_t  mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wr(input logic [REG_ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr_q.push_back(w);
  endtask

  // Monitor: every grant and every register-file write is matched against
  // the expectation queues filled by the stimulus.
  always @(negedge clock) begin
    if (bus.req_ready != '0) begin
      if (exp_grant_q.size() == 0) begin
        check("unexpected_grant", 32'(bus.req_ready), 32'd0);
      end else begin
        mon_g = exp_grant_q.pop_front();
        check("grant", 32'(bus.req_ready), 32'd1 << mon_g);
      end
    end
    if (bus.wr_en) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
      end else begin
        mon_w = exp_wr_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(mon_w.addr));
        check("wr_data", bus.wr_data, mon_w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;

    // Requests held during reset must not be granted.
    bus.req_valid = 2'b11;
    #12;
    check("ready_in_reset", 32'(bus.req_ready), 32'd0);
    check("wr_en_in_reset", 32'(bus.wr_en), 32'd0);
    bus.req_valid = '0;
    tick();
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_ready", 32'(bus.req_ready), 32'd0);
      check("idle_wr_en", 32'(bus.wr_en), 32'd0);
      check("idle_busy", bus.busy, 32'd0);
    end
    tick();

    // Requester 0 alone; pointer moves to 1.
    bus.req_addr  = {5'd0, 5'd5};
    bus.req_data  = {32'h0, 32'hDEAD_BEEF};
    bus.req_valid = 2'b01;
    exp_grant_q.push_back(0);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    @(negedge clock);
    check("solo_ready_same_cycle", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = '0;
    @(negedge clock);
    check("solo_wr_en_next_cycle", 32'(bus.wr_en), 32'd1);
    tick();

    // Requester 1 writes x0: consumed, never written; pointer back to 0.
    bus.req_addr  = {5'd0, 5'd0};
    bus.req_data  = {32'hFFFF_FFFF, 32'h0};
    bus.req_valid = 2'b10;
    exp_grant_q.push_back(1);
    @(negedge clock);
    check("x0_ready", 32'(bus.req_ready), 32'd2);
    tick();
    bus.req_valid = '0;
    @(negedge clock);
    check("x0_wr_en_low", 32'(bus.wr_en), 32'd0);
    check("x0_busy0_low", 32'(bus.busy[0]), 32'd0);
    tick();

    // Both valid continuously: grants 0,1,0,1.
    bus.req_addr  = {5'd4, 5'd3};
    bus.req_data  = {32'h22, 32'h11};
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) exp_grant_q.push_back(i % 2);
    expect_wr(5'd3, 32'h11);
    expect_wr(5'd4, 32'h22);
    expect_wr(5'd3, 32'h11);
    expect_wr(5'd4, 32'h22);
    repeat (4) tick();
    bus.req_valid = '0;
    repeat (2) tick();

    // Scoreboard: issue rd 7 sets busy[7]; issue rd 0 ignored.
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    tick();
    bus.issue_rd    = 5'd0;
    check("busy7_set", 32'(bus.busy[7]), 32'(SB));
    tick();
    bus.issue_valid = 1'b0;
    check("busy_x0_ignored", bus.busy, SB ? 32'h80 : 32'h0);

    // Write-back to 7 from requester 0: busy holds during the wr_en cycle,
    // clears at the commit edge.
    bus.req_addr  = {5'd0, 5'd7};
    bus.req_data  = {32'h0, 32'h77};
    bus.req_valid = 2'b01;
    exp_grant_q.push_back(0);
    expect_wr(5'd7, 32'h77);
    tick();
    bus.req_valid = '0;
    check("busy7_until_commit", 32'(bus.busy[7]), 32'(SB));
    tick();
    check("busy7_cleared", 32'(bus.busy[7]), 32'd0);

    // Write-back to 7 from requester 1 with a re-issue of 7 in the commit
    // cycle: set wins.
    bus.req_addr  = {5'd7, 5'd0};
    bus.req_data  = {32'h78, 32'h0};
    bus.req_valid = 2'b10;
    exp_grant_q.push_back(1);
    expect_wr(5'd7, 32'h78);
    tick();
    bus.req_valid   = '0;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    tick();
    bus.issue_valid = 1'b0;
    check("busy7_set_wins", 32'(bus.busy[7]), 32'(SB));

    // Transfer to 9 then reset in the write cycle: write discarded.
    bus.req_addr  = {5'd0, 5'd9};
    bus.req_data  = {32'h0, 32'h99};
    bus.req_valid = 2'b01;
    exp_grant_q.push_back(0);
    tick();
    bus.req_valid = '0;
    reset = 1'b0;
    #1;
    check("rst_wr_en_dropped", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_busy_cleared", bus.busy, 32'd0);
    tick();
    reset = 1'b1;

    // Pointer back at 0: both valid grants requester 0 first.
    bus.req_addr  = {5'd4, 5'd3};
    bus.req_data  = {32'h22, 32'h11};
    bus.req_valid = 2'b11;
    exp_grant_q.push_back(0);
    expect_wr(5'd3, 32'h11);
    @(negedge clock);
    check("post_rst_grant0", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = '0;
    repeat (2) tick();

    check("grant_queue_drained", 32'(exp_grant_q.size()), 32'd0);
    check("write_queue_drained", 32'(exp_wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
